sprite_compositor: RTL and testbench

//   Parametrised N-sprite / M-bullet pixel compositor between VGATimingGenerator and the VGA pins.
//   Per-frame shadow registers give tear-free position updates. Priority runs sprite0 > ... > spriteN-1 > bullets > background.

---
 rtl/sprite_pkg.sv | 22 ++
 rtl/sprite_compositor_pixel_delay.sv | 31 +++
 rtl/sprite_compositor.sv | 185 ++++++++++++++++++
 tb/tb_sprite_compositor.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared field offsets and helpers for the sprite compositor.
// Bullet and sprite word layouts plus the 11-bit box test.
package sprite_pkg;
  localparam int RGB_W  = 12;
  localparam int BX_MSB = 31;
  localparam int BX_LSB = 22;
  localparam int BY_MSB = 21;
  localparam int BY_LSB = 13;
  localparam int BACT   = 2;
  localparam int SX_MSB = 9;
  localparam int SX_LSB = 0;
  localparam int SY_MSB = 24;
  localparam int SY_LSB = 16;

  function automatic logic in_box(
    input logic [10:0] p,
    input logic [10:0] s,
    input logic [10:0] size
  );
    return (p >= s) && (p < s + size);
  endfunction
endpackage

// File: rtl/sprite_compositor_pixel_delay.sv
// Reset-to-value shift register used to align flags and syncs
// with data returning from the external ROMs.
module pixel_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= {DEPTH{RST_VAL}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign q = pipe_q[DEPTH-1];
endmodule

// File: rtl/sprite_compositor.sv
// N-sprite / M-bullet pixel compositor with per-frame shadow
// registers and ROM-latency-matched sync alignment.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 2,
  parameter int SPRITE_SIZE = 64,
  parameter int NUM_BULLETS = 64,
  parameter int BULLET_SIZE = 12,
  parameter int ROM_LATENCY = 1,
  parameter logic [RGB_W-1:0] TRANSPARENT_RGB = 12'h0F0,
  parameter logic [RGB_W-1:0] BULLET_RGB = 12'hF00,
  localparam int AW = $clog2(SPRITE_SIZE*SPRITE_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   x,
  input  logic [8:0]                   y,
  input  logic                         active,
  input  logic                         hSync_in,
  input  logic                         vSync_in,
  input  logic                         screenEnd,
  input  logic                         freeze,
  input  logic [32*NUM_SPRITES-1:0]    sprite_pos,
  input  logic [NUM_SPRITES-1:0]       sprite_en,
  input  logic [32*NUM_BULLETS-1:0]    bullet_table,
  output logic [AW*NUM_SPRITES-1:0]    sprite_addr,
  input  logic [RGB_W*NUM_SPRITES-1:0] sprite_rgb,
  output logic [18:0]                  bg_addr,
  input  logic [RGB_W-1:0]             bg_rgb,
  output logic                         hSync,
  output logic                         vSync,
  output logic [3:0]                   VGA_R,
  output logic [3:0]                   VGA_G,
  output logic [3:0]                   VGA_B,
  output logic [15:0]                  frame_cnt
);
  localparam int NS = NUM_SPRITES;
  localparam int NB = NUM_BULLETS;
  localparam int LW = AW / 2;
  localparam int DW = NS + 4;
  localparam logic [10:0] SSZ = 11'(SPRITE_SIZE);
  localparam logic [10:0] BSZ = 11'(BULLET_SIZE);
  localparam logic [DW-1:0] DLY_RST = {2'b11, {(NS+2){1'b0}}};

  logic [NS-1:0][9:0] sx_q, sx_d;
  logic [NS-1:0][8:0] sy_q, sy_d;
  logic [NS-1:0]      sen_q, sen_d;
  logic [NB-1:0][9:0] bx_q, bx_d;
  logic [NB-1:0][8:0] by_q, by_d;
  logic [NB-1:0]      bact_q, bact_d;
  logic [15:0]        frame_q, frame_d;
  logic               unused_in;

  assign unused_in = ^{sprite_pos, bullet_table};

  // Live inputs are only sampled here, so mid-frame writes never tear.
  always_comb begin
    sx_d = sx_q; sy_d = sy_q; sen_d = sen_q;
    bx_d = bx_q; by_d = by_q; bact_d = bact_q;
    frame_d = frame_q;
    if (screenEnd) begin
      frame_d = frame_q + 16'd1;
      if (!freeze) begin
        for (int i = 0; i < NS; i++) begin
          sx_d[i] = sprite_pos[32*i+SX_LSB +: 10];
          sy_d[i] = sprite_pos[32*i+SY_LSB +: 9];
        end
        sen_d = sprite_en;
        for (int b = 0; b < NB; b++) begin
          bx_d[b]   = bullet_table[32*b+BX_LSB +: 10];
          by_d[b]   = bullet_table[32*b+BY_LSB +: 9];
          bact_d[b] = bullet_table[32*b+BACT];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sx_q <= '0; sy_q <= '0; sen_q <= '0;
      bx_q <= '0; by_q <= '0; bact_q <= '0;
      frame_q <= '0;
    end else begin
      sx_q <= sx_d; sy_q <= sy_d; sen_q <= sen_d;
      bx_q <= bx_d; by_q <= by_d; bact_q <= bact_d;
      frame_q <= frame_d;
    end
  end

  logic [10:0]           x_w, y_w;
  logic [NS-1:0]         hit_d, hit_q;
  logic [NS-1:0][AW-1:0] addr_d, addr_q;
  logic [NB-1:0]         bhit_v;
  logic                  bhit_d, bhit_q;
  logic [18:0]           bg_addr_d, bg_addr_q;
  logic                  act1_q, hs1_q, vs1_q;

  assign x_w = {1'b0, x};
  assign y_w = {2'b0, y};

  for (genvar s = 0; s < NS; s++) begin : g_spr
    logic [LW-1:0] dx, dy;
    assign hit_d[s] = sen_q[s]
      & in_box(x_w, {1'b0, sx_q[s]}, SSZ)
      & in_box(y_w, {2'b0, sy_q[s]}, SSZ);
    // Low-bit subtraction keeps the address inside the ROM off-sprite.
    assign dx = x[LW-1:0] - sx_q[s][LW-1:0];
    assign dy = y[LW-1:0] - sy_q[s][LW-1:0];
    assign addr_d[s] = {dy, dx};
  end

  for (genvar b = 0; b < NB; b++) begin : g_blt
    assign bhit_v[b] = bact_q[b]
      & in_box(x_w, {1'b0, bx_q[b]}, BSZ)
      & in_box(y_w, {2'b0, by_q[b]}, BSZ);
  end

  assign bhit_d = |bhit_v;
  assign bg_addr_d = 19'(x) + 19'(y) * 19'd640;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= '0; bhit_q <= 1'b0; act1_q <= 1'b0;
      hs1_q <= 1'b1; vs1_q <= 1'b1;
      addr_q <= '0; bg_addr_q <= '0;
    end else begin
      hit_q <= hit_d; bhit_q <= bhit_d; act1_q <= active;
      hs1_q <= hSync_in; vs1_q <= vSync_in;
      addr_q <= addr_d; bg_addr_q <= bg_addr_d;
    end
  end

  assign sprite_addr = addr_q;
  assign bg_addr = bg_addr_q;

  logic [DW-1:0] dly_in, dly_out;
  logic [NS-1:0] d_hit;
  logic          d_bhit, d_act, d_hs, d_vs;

  assign dly_in = {hs1_q, vs1_q, act1_q, bhit_q, hit_q};
  assign {d_hs, d_vs, d_act, d_bhit, d_hit} = dly_out;

  pixel_delay #(
    .WIDTH   (DW),
    .DEPTH   (ROM_LATENCY),
    .RST_VAL (DLY_RST)
  ) u_dly (
    .clk   (clk),
    .reset (reset),
    .d     (dly_in),
    .q     (dly_out)
  );

  logic [RGB_W-1:0] rgb_d, rgb_q;
  logic             found;
  logic             hs_q, vs_q;

  always_comb begin
    found = 1'b0;
    rgb_d = bg_rgb;
    for (int i = 0; i < NS; i++) begin
      if (!found && d_hit[i] &&
          sprite_rgb[RGB_W*i +: RGB_W] != TRANSPARENT_RGB) begin
        rgb_d = sprite_rgb[RGB_W*i +: RGB_W];
        found = 1'b1;
      end
    end
    if (!found && d_bhit) rgb_d = BULLET_RGB;
    if (!d_act) rgb_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= '0; hs_q <= 1'b1; vs_q <= 1'b1;
    end else begin
      rgb_q <= rgb_d; hs_q <= d_hs; vs_q <= d_vs;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign hSync = hs_q;
  assign vSync = vs_q;
  assign frame_cnt = frame_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// Randomized and directed bench for sprite_compositor against a
// pixel-level reference model with external ROM models.
module tb_sprite_compositor;
  localparam int NS = 2;
  localparam int SZ = 64;
  localparam int NB = 64;
  localparam int BS = 12;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset, active, hs_in, vs_in, screen_end, freeze;
  logic [9:0] x;
  logic [8:0] y;
  logic [32*NS-1:0] sprite_pos;
  logic [NS-1:0] sprite_en;
  logic [32*NB-1:0] bullet_table;
  logic [AW*NS-1:0] sprite_addr;
  logic [12*NS-1:0] sprite_rgb;
  logic [18:0] bg_addr;
  logic [11:0] bg_rgb;
  logic hsync, vsync;
  logic [3:0] vga_r, vga_g, vga_b;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  sprite_compositor #(
    .NUM_SPRITES (NS), .SPRITE_SIZE (SZ), .NUM_BULLETS (NB),
    .BULLET_SIZE (BS), .ROM_LATENCY (1),
    .TRANSPARENT_RGB (12'h0F0), .BULLET_RGB (12'hF00)
  ) dut (
    .clk (clk), .reset (reset), .x (x), .y (y), .active (active),
    .hSync_in (hs_in), .vSync_in (vs_in), .screenEnd (screen_end),
    .freeze (freeze), .sprite_pos (sprite_pos), .sprite_en (sprite_en),
    .bullet_table (bullet_table), .sprite_addr (sprite_addr),
    .sprite_rgb (sprite_rgb), .bg_addr (bg_addr), .bg_rgb (bg_rgb),
    .hSync (hsync), .vSync (vsync), .VGA_R (vga_r), .VGA_G (vga_g),
    .VGA_B (vga_b), .frame_cnt (frame_cnt)
  );

  bit use_const;
  logic [11:0] rom_const [NS];

  function automatic logic [11:0] rom_fn(int i, int a);
    if (use_const) return rom_const[i];
    if (a % 8 == 0) return 12'h0F0;
    return 12'((a * 37 + i * 1000 + 5) % 4096);
  endfunction

  function automatic logic [11:0] bg_fn(int a);
    return 12'((a * 13 + 7) % 4096);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++)
      sprite_rgb[i*12 +: 12] <= rom_fn(i, int'(sprite_addr[i*AW +: AW]));
    bg_rgb <= bg_fn(int'(bg_addr));
  end

  int m_sx [NS], m_sy [NS];
  bit m_en [NS];
  int m_bx [NB], m_by [NB];
  bit m_ba [NB];
  logic [15:0] m_frame;

  typedef struct {
    logic [11:0] rgb;
    logic hs;
    logic vs;
  } exp_t;
  exp_t exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(int px, int py, bit act);
    logic [11:0] c;
    if (!act) return 12'h000;
    for (int i = 0; i < NS; i++) begin
      if (m_en[i] && px >= m_sx[i] && px < m_sx[i] + SZ &&
          py >= m_sy[i] && py < m_sy[i] + SZ) begin
        c = rom_fn(i, (px - m_sx[i]) + SZ * (py - m_sy[i]));
        if (c != 12'h0F0) return c;
      end
    end
    for (int b = 0; b < NB; b++)
      if (m_ba[b] && px >= m_bx[b] && px < m_bx[b] + BS &&
          py >= m_by[b] && py < m_by[b] + BS) return 12'hF00;
    return bg_fn(px + 640 * py);
  endfunction

  task automatic latch();
    for (int i = 0; i < NS; i++) begin
      m_sx[i] = int'(sprite_pos[i*32 +: 10]);
      m_sy[i] = int'(sprite_pos[i*32+16 +: 9]);
      m_en[i] = sprite_en[i];
    end
    for (int b = 0; b < NB; b++) begin
      m_bx[b] = int'(bullet_table[b*32+22 +: 10]);
      m_by[b] = int'(bullet_table[b*32+13 +: 9]);
      m_ba[b] = bullet_table[b*32+2];
    end
  endtask

  task automatic step(int px, int py, bit act, bit hs, bit vs,
                      bit se, bit fr);
    exp_t e;
    x = 10'(px); y = 9'(py); active = act;
    hs_in = hs; vs_in = vs; screen_end = se; freeze = fr;
    e.rgb = model_rgb(px, py, act);
    e.hs = hs; e.vs = vs;
    exp_q.push_back(e);
    if (se) begin
      m_frame++;
      if (!fr) latch();
    end
    @(posedge clk); #1;
    check("frame_cnt", 32'(frame_cnt), 32'(m_frame));
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
      check("hsync", 32'(hsync), 32'(e.hs));
      check("vsync", 32'(vsync), 32'(e.vs));
    end
  endtask

  task automatic pix(int px, int py);
    step(px, py, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic frame(bit fr);
    step(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, fr);
  endtask

  task automatic set_rom(logic [11:0] c0, logic [11:0] c1);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    use_const = 1'b1; rom_const[0] = c0; rom_const[1] = c1;
  endtask

  task automatic set_sprite(int i, int sx, int sy, bit en);
    sprite_pos[i*32 +: 32] = {7'd0, 9'(sy), 6'd0, 10'(sx)};
    sprite_en[i] = en;
  endtask

  task automatic set_bullet(int b, int bx, int by, bit act);
    bullet_table[b*32 +: 32] = {10'(bx), 9'(by), 10'd0, act, 2'd0};
  endtask

  task automatic do_reset();
    reset = 1'b1; screen_end = 1'b1; freeze = 1'b0;
    hs_in = 1'b0; vs_in = 1'b0; active = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("rst_hsync", 32'(hsync), 32'h1);
    check("rst_vsync", 32'(vsync), 32'h1);
    check("rst_frame", 32'(frame_cnt), 32'h0);
    reset = 1'b0; screen_end = 1'b0;
    exp_q.delete();
    m_frame = 16'd0;
    for (int i = 0; i < NS; i++) m_en[i] = 1'b0;
    for (int b = 0; b < NB; b++) m_ba[b] = 1'b0;
  endtask

  int px, py, t, k;

  initial begin
    reset = 1'b0; x = '0; y = '0; active = 1'b0;
    hs_in = 1'b1; vs_in = 1'b1; screen_end = 1'b0; freeze = 1'b0;
    sprite_pos = '0; sprite_en = '0; bullet_table = '0;
    use_const = 1'b1; rom_const[0] = 12'h0; rom_const[1] = 12'h0;
    do_reset();

    for (int i = 0; i < 8; i++)
      step(0, 0, 1'b0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0, 1'b0);

    set_sprite(0, 100, 50, 1'b1);
    set_sprite(1, 0, 0, 1'b0);
    frame(1'b0);
    set_rom(12'h123, 12'h456);
    pix(100, 50);
    pix(164, 50);
    pix(101, 51);
    check("saddr_101_51", 32'(sprite_addr[0 +: AW]), 32'(1 + SZ * 1));
    pix(163, 113);
    check("saddr_corner", 32'(sprite_addr[0 +: AW]), 32'(63 + SZ * 63));
    pix(99, 50);

    set_sprite(0, 180, 180, 1'b1);
    set_sprite(1, 190, 190, 1'b1);
    frame(1'b0);
    set_rom(12'h0F0, 12'h456);
    pix(200, 200);
    set_rom(12'h0AB, 12'h456);
    pix(200, 200);
    set_sprite(0, 180, 180, 1'b0);
    frame(1'b0);
    pix(200, 200);

    set_sprite(1, 0, 0, 1'b0);
    set_bullet(5, 300, 300, 1'b1);
    frame(1'b0);
    pix(311, 311);
    pix(312, 300);
    pix(300, 300);
    set_sprite(0, 300, 300, 1'b1);
    set_rom(12'h321, 12'h456);
    frame(1'b0);
    pix(311, 311);
    pix(312, 312);

    set_bullet(5, 0, 0, 1'b0);
    set_sprite(0, 100, 50, 1'b1);
    frame(1'b0);
    pix(100, 50);
    set_sprite(0, 400, 50, 1'b1);
    pix(100, 50);
    pix(400, 50);
    frame(1'b1);
    pix(100, 50);
    pix(400, 50);
    frame(1'b0);
    pix(400, 50);
    pix(100, 50);

    set_sprite(0, 620, 470, 1'b1);
    frame(1'b0);
    for (int i = 610; i < 640; i++) pix(i, 475);
    for (int i = 0; i < 50; i++) pix(i, 475);
    for (int j = 465; j < 480; j++) pix(625, j);
    for (int j = 0; j < 6; j++) pix(625, j);

    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    use_const = 1'b0;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < NS; i++)
        set_sprite(i, $urandom_range(0, 700), $urandom_range(0, 480),
                   1'($urandom_range(0, 3) != 0));
      for (int b = 0; b < NB; b++)
        set_bullet(b, $urandom_range(0, 700), $urandom_range(0, 480),
                   1'($urandom_range(0, 4) < 2));
      frame(1'($urandom_range(0, 3) == 0));
      for (int n = 0; n < 200; n++) begin
        t = $urandom_range(0, 3);
        if (t == 0) begin
          px = $urandom_range(0, 700); py = $urandom_range(0, 500);
        end else if (t < 3) begin
          px = m_sx[t-1] + $urandom_range(0, SZ + 4) - 2;
          py = m_sy[t-1] + $urandom_range(0, SZ + 4) - 2;
        end else begin
          k = $urandom_range(0, NB - 1);
          px = m_bx[k] + $urandom_range(0, BS + 2) - 1;
          py = m_by[k] + $urandom_range(0, BS + 2) - 1;
        end
        if (px < 0) px = 0;
        if (px > 1023) px = 1023;
        if (py < 0) py = 0;
        if (py > 511) py = 511;
        if (n % 64 == 63)
          set_sprite(0, $urandom_range(0, 700), $urandom_range(0, 480),
                     1'b1);
        step(px, py, 1'($urandom_range(0, 9) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'b0, 1'b0);
      end
    end

    do_reset();
    while (m_frame != 16'hFFFF)
      step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("frame_wrap", 32'(frame_cnt), 32'h0);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
